// File: rtl/joy_db15_tx.sv
// joy_db15_tx: adapter-side DB15 joystick shift chain (parallel-in/serial-out, 32-bit frame); optional JOYTX_SYNC_EN.
// Latency: JOY_CLK pin edge to JOY_DATA is 1 clk (3 clk with JOYTX_SYNC_EN synchronizers).
// Backpressure: none; the receiver's JOY_CLK/JOY_LOAD pace the transfer and every edge is honoured.
module joy_db15_tx #(
  parameter int DATA_INVERT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        JOY_CLK,
  input  logic        JOY_LOAD,
  output logic        JOY_DATA,
  output logic        busy,
  output logic        frame_done,
  output logic [5:0]  bit_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] shreg, shreg_nxt;
  logic [31:0] frame;
  logic [5:0]  cnt_nxt;
  logic        done_nxt;
  logic        jclk, jload, jclk_prev, clk_rise;

`ifdef JOYTX_SYNC_EN
  logic [1:0] clk_sync, load_sync;

  // Released-level reset value keeps the first sampled edge after reset from looking like a load or shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      load_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], JOY_CLK};
      load_sync <= {load_sync[0], JOY_LOAD};
    end
  end

  assign jclk  = clk_sync[1];
  assign jload = load_sync[1];
`else
  assign jclk  = JOY_CLK;
  assign jload = JOY_LOAD;
`endif

  assign frame    = (DATA_INVERT != 0) ? ~{joystick2, joystick1} : {joystick2, joystick1};
  assign clk_rise = jclk & ~jclk_prev;
  assign JOY_DATA = shreg[0];
  assign busy     = (state == SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '1;
      bit_cnt    <= 6'd0;
      frame_done <= 1'b0;
      jclk_prev  <= 1'b1;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= cnt_nxt;
      frame_done <= done_nxt;
      jclk_prev  <= jclk;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    done_nxt  = 1'b0;
    // A low load strobe overrides everything, including a coincident clock edge.
    if (!jload) begin
      state_nxt = LOAD;
      shreg_nxt = frame;
      cnt_nxt   = 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (clk_rise) shreg_nxt = {1'b1, shreg[31:1]};
        end
        LOAD: begin
          state_nxt = SHIFT;
        end
        SHIFT: begin
          if (clk_rise) begin
            shreg_nxt = {1'b1, shreg[31:1]};
            cnt_nxt   = bit_cnt + 6'd1;
            if (bit_cnt == 6'd31) begin
              state_nxt = DRAIN;
              done_nxt  = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (clk_rise) shreg_nxt = {1'b1, shreg[31:1]};
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: doc/joy_db15_tx.md
# joy_db15_tx

Transmitter for the DB15 serial joystick link: it emulates the adapter's parallel-in/serial-out shift chain. On the load strobe it captures two 16-bit player words, then shifts them out one bit per rising edge of the serial clock. It sits opposite `joy_db15`, on the adapter side. It is used as the loopback source in the joystick benches and as the adapter model in system simulation.

## Interface
- `DATA_INVERT`, default 1: 1 = the cable carries active-low buttons, so frame bits are inverted before shifting; 0 = bits are sent as-is.
- `clk`  in  1  system clock, 40–50 MHz. Every register is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `joystick1`  in  16  player 1 buttons, active-high, same bit map as the receiver output.
- `joystick2`  in  16  player 2 buttons, active-high.
- `JOY_CLK`  in  1  serial shift clock from the receiver; asynchronous to `clk`.
- `JOY_LOAD`  in  1  parallel-load strobe from the receiver, active-low; asynchronous to `clk`.
- `JOY_DATA`  out  1  serial data to the receiver.
- `busy`  out  1  high while a loaded frame still has unshifted bits.
- `frame_done`  out  1  one-cycle pulse when the 32nd bit has been shifted past.
- `bit_cnt`  out  6  number of shifts since the last load, 0..32.

## Operation
- Frame layout: 32 bits. Frame bit k is `joystick1[k]` for k = 0..15 and `joystick2[k-16]` for k = 16..31. Each bit is inverted when DATA_INVERT = 1.
- `JOY_DATA` is always shift-register bit 0. The serial-in end of the register is tied to 1, so a drained chain reads released / pull-up.
- States:
  - IDLE: register all ones, `bit_cnt` = 0.
  - LOAD: while `JOY_LOAD` is low, the register is reloaded from the inputs every cycle (transparent, like a '165). `bit_cnt` = 0 and clock edges are ignored.
  - SHIFT: each detected `JOY_CLK` rising edge shifts the register right by one and increments `bit_cnt`.
  - DRAIN: entered when `bit_cnt` reaches 32.
- Transitions:
  - IDLE, SHIFT or DRAIN → LOAD when `JOY_LOAD` is low.
  - LOAD → SHIFT on the `JOY_LOAD` rising edge.
  - SHIFT → DRAIN on the 32nd shift; `frame_done` pulses in that same cycle.
  - DRAIN → DRAIN on further edges: register keeps shifting in 1s, `bit_cnt` saturates at 32, no further `frame_done`.
- `busy` = 1 in SHIFT and 0 in every other state.
- Edge detection: the previous sampled value of `JOY_CLK` is kept. A rising edge is registered as previous = 0 and current = 1. Falling edges of `JOY_CLK` have no effect.

## Timing
- Reset values: register all ones, `JOY_DATA` = 1, `busy` = 0, `frame_done` = 0, `bit_cnt` = 0, state IDLE.
- Reset is asynchronous. Asserting it mid-frame returns the block to IDLE immediately. After release, the block waits for a `JOY_LOAD` low; stray `JOY_CLK` edges in IDLE shift 1s and do not change `bit_cnt`.
- Latency from a pin edge to the `JOY_DATA` update:
  - with JOYTX_SYNC_EN: 3 `clk` cycles (two synchronizer stages plus the edge register);
  - without it: 1 cycle.
- The `JOY_CLK` high and low phases must each be at least 4 `clk` cycles. Shorter pulses may be missed; this is out of spec and not checked.
- A `JOY_LOAD` low coinciding with a `JOY_CLK` rising edge: the load wins and the edge is discarded.
- A `JOY_LOAD` low in mid-frame aborts the frame with no `frame_done`.
- Input changes during SHIFT or DRAIN do not alter the frame already in flight.

## Configuration
- `JOYTX_SYNC_EN` defined: `JOY_CLK` and `JOY_LOAD` each pass through a 2-flop synchronizer, with synchronizer reset value 1, before edge detection.
- `JOYTX_SYNC_EN` undefined: the pins feed the edge logic directly, which gives 1-cycle latency. This is only for benches where the pins are driven synchronously to `clk`.

## Test plan
- **Reset:** assert `reset` with random inputs → `JOY_DATA` = 1, `bit_cnt` = 0, `busy` = 0, `frame_done` = 0.
- **Full frame:** `joystick1` = 16'h0001, `joystick2` = 16'h8000, DATA_INVERT = 1; pulse `JOY_LOAD`, then 32 `JOY_CLK` rising edges.
  - Serial stream reads 0, then 1 for bits 1..30, then 0 at bit 31.
  - `frame_done` pulses exactly once, on edge 32.
  - A 33rd edge gives `JOY_DATA` = 1 and `bit_cnt` = 32.
- **Held load:** hold `JOY_LOAD` low while toggling `JOY_CLK` 5 times and changing `joystick1` from 0 to 16'hFFFF → `bit_cnt` stays 0 and `JOY_DATA` follows the new bit 0 (0 with inversion).
- **Abort:** after 10 shifts, pulse `JOY_LOAD` → `bit_cnt` returns to 0, no `frame_done`, frame restarts at bit 0.
- **Simultaneous events:** `JOY_LOAD` falls in the same cycle as a `JOY_CLK` rising edge → no shift; `bit_cnt` = 0 after load release.
- **Sync latency:** with JOYTX_SYNC_EN, `JOY_DATA` changes exactly 3 `clk` cycles after the `JOY_CLK` pin rises. Reset asserted mid-frame, at bit 20, forces `JOY_DATA` = 1 combinationally.
